// File: rtl/dice_roller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dice_roller: debounced roll button, timed tumble, two frozen LFSR die faces.
// Rev 1.0
// ----------------------------------------------------------------------------
module dice_roller #(
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          STEP_CYCLES     = 50000,
  parameter int          ROLL_CYCLES     = 1000000,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [3:0] dice1,
  output logic [3:0] dice2,
  output logic       stop,
  output logic       rolling,
  output logic [3:0] sum,
  output logic       double
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int RL_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(STEP_CYCLES - 1);
  localparam logic [RL_W-1:0] ROLL_LAST = RL_W'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    STOP = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic            btn_db;
  logic            db_q;
  logic [DB_W-1:0] db_cnt;
  logic [ST_W-1:0] step_cnt;
  logic [RL_W-1:0] roll_cnt;
  logic            press;

  assign press = btn_db & ~db_q;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1 (tap mask 0xB400).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Out-of-range candidates (0, 7) keep the old face so a rolled die never blanks.
  function automatic logic [3:0] pick_face(input logic [2:0] cand, input logic [3:0] prev);
    if (cand == 3'd0 || cand == 3'd7)
      return (prev == 4'd0) ? 4'd1 : prev;
    return {1'b0, cand};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      btn_db   <= 1'b0;
      db_q     <= 1'b0;
      db_cnt   <= '0;
      step_cnt <= '0;
      roll_cnt <= '0;
      dice1    <= 4'd0;
      dice2    <= 4'd0;
      stop     <= 1'b0;
      rolling  <= 1'b0;
      sum      <= 4'd0;
      double   <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      db_q <= btn_db;
      if (btn == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      sum  <= dice1 + dice2;
      stop <= 1'b0;

      case (state)
        IDLE: begin
          dice1  <= 4'd0;
          dice2  <= 4'd0;
          double <= 1'b0;
          if (press) begin
            state    <= ROLL;
            rolling  <= 1'b1;
            roll_cnt <= '0;
            step_cnt <= '0;
          end
        end
        ROLL: begin
          if (step_cnt == '0) begin
            dice1 <= pick_face(lfsr[2:0], dice1);
            dice2 <= pick_face(lfsr[10:8], dice2);
          end
          step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
          roll_cnt <= roll_cnt + 1'b1;
          if (press || roll_cnt == ROLL_LAST) begin
            state   <= STOP;
            stop    <= 1'b1;
            rolling <= 1'b0;
          end
        end
        STOP: begin
          state  <= SHOW;
          double <= (dice1 == dice2);
        end
        SHOW: begin
          if (press) begin
            state    <= ROLL;
            rolling  <= 1'b1;
            roll_cnt <= '0;
            step_cnt <= '0;
            double   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
